// File: rtl/dec_pkg.sv
// rtl/dec_pkg.sv - shared state encoding and constants for the decrypt-and-verify controller
package dec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_CHECK,
        ST_SHOW,
        ST_FAIL
    } state_t;

    // Fixed upper 112 ciphertext bits; the switches supply the low 16.
    localparam logic [111:0] CT_HI      = 112'h646e277420646563727970742074;

    // Active-low {g,f,e,d,c,b,a} patterns.
    localparam logic [6:0]   FAIL_GLYPH = 7'b0001110;
    localparam logic [6:0]   BLANK      = 7'b1111111;

endpackage

// File: rtl/dec_verify_top_hex_to_seg.sv
// rtl/dec_verify_top_hex_to_seg.sv - nibble to active-low seven-segment pattern
//   nib : 4-bit hex digit
//   seg : {g,f,e,d,c,b,a}, active-low, combinational
module hex_to_seg (
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/dec_verify_top.sv
// rtl/dec_verify_top.sv - decrypt-and-verify controller between board I/O and an external decryption core
//   clk, rst            : clock, synchronous active-high reset
//   start, sw, tag_ref  : request, ciphertext low bits, expected tag
//   core_start, core_c  : start pulse and ciphertext to the core
//   core_p, core_tag,   : plaintext, recomputed tag, completion from the core
//   core_done
//   busy, auth_ok,      : status flags (LOAD/RUN/CHECK, SHOW, FAIL)
//   auth_fail
//   seg, an             : active-low seven-segment segments and digit enables
module dec_verify_top
    import dec_pkg::*;
#(
    parameter int SCAN_BITS = 21,
    parameter int TIMEOUT   = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [15:0]  sw,
    input  logic [127:0] tag_ref,
    output logic         core_start,
    output logic [127:0] core_c,
    input  logic [127:0] core_p,
    input  logic [127:0] core_tag,
    input  logic         core_done,
    output logic         busy,
    output logic         auth_ok,
    output logic         auth_fail,
    output logic [6:0]   seg,
    output logic [7:0]   an
);

    localparam int            CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    state_t               state;
    logic [CW-1:0]        wait_cnt;
    logic [SCAN_BITS-1:0] scan;
    logic [127:0]         tag_reg;
    logic [127:0]         tag_cand;
    // Only the low 32 plaintext bits ever reach the eight display digits.
    logic [31:0]          pt_cand;
    logic [31:0]          pt_reg;
    logic                 unused_pt_hi;

    logic [2:0]           dig;
    logic [4:0]           nib_base;
    logic [6:0]           hex_seg;

    assign unused_pt_hi = ^core_p[127:32];
    assign dig          = scan[SCAN_BITS-1 -: 3];
    assign nib_base     = {dig, 2'b00};

    hex_to_seg u_hex (
        .nib (pt_reg[nib_base +: 4]),
        .seg (hex_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            auth_ok    <= 1'b0;
            auth_fail  <= 1'b0;
            core_start <= 1'b0;
            core_c     <= '0;
            tag_reg    <= '0;
            tag_cand   <= '0;
            pt_cand    <= '0;
            pt_reg     <= '0;
            wait_cnt   <= '0;
        end else begin
            core_start <= 1'b0;
            case (state)
                ST_IDLE, ST_SHOW, ST_FAIL: begin
                    // LOAD work is done on the entry edge so core_c, tag_reg
                    // and the start pulse are all valid during the LOAD cycle.
                    if (start) begin
                        state      <= ST_LOAD;
                        core_c     <= {CT_HI, sw};
                        tag_reg    <= tag_ref;
                        pt_reg     <= '0;
                        core_start <= 1'b1;
                        busy       <= 1'b1;
                        auth_ok    <= 1'b0;
                        auth_fail  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    state    <= ST_RUN;
                    wait_cnt <= '0;
                end
                ST_RUN: begin
                    if (core_done) begin
                        pt_cand  <= core_p[31:0];
                        tag_cand <= core_tag;
                        state    <= ST_CHECK;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state     <= ST_FAIL;
                        busy      <= 1'b0;
                        auth_fail <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    busy <= 1'b0;
                    if (tag_cand == tag_reg) begin
                        pt_reg  <= pt_cand;
                        state   <= ST_SHOW;
                        auth_ok <= 1'b1;
                    end else begin
                        state     <= ST_FAIL;
                        auth_fail <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan <= '0;
            an   <= 8'hFF;
            seg  <= BLANK;
        end else begin
            scan <= scan + 1'b1;
            case (state)
                ST_SHOW: begin
                    an  <= ~(8'b1 << dig);
                    seg <= hex_seg;
                end
                ST_FAIL: begin
                    an  <= ~(8'b1 << dig);
                    seg <= FAIL_GLYPH;
                end
                default: begin
                    an  <= 8'hFF;
                    seg <= BLANK;
                end
            endcase
        end
    end

endmodule

// File: doc/dec_verify_top.md
# dec_verify_top

Board-level decrypt-and-verify controller; the receive-side counterpart of the encrypt top level. It captures a 128-bit ciphertext (fixed upper 112 bits plus 16 switch bits) and drives an external authenticated-decryption core through a start/done handshake. It compares the recomputed tag against the received tag and releases plaintext to the 8-digit seven-segment display only on an exact match. The block sits between the board I/O (switches, button, display) and the decryption core.

## Interface
Parameters:
- SCAN_BITS, 21, width of free-running display scan counter; digit select = scan[SCAN_BITS-1 -: 3]
- TIMEOUT, 4096, max cycles in RUN before declaring failure

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  decrypt request, level sampled each cycle (debounced upstream)
- sw  in  16  ciphertext bits [15:0]
- tag_ref  in  128  received tag to verify against
- core_start  out  1  one-cycle start pulse to decryption core
- core_c  out  128  ciphertext to core, held stable from LOAD until leaving RUN
- core_p  in  128  plaintext from core, valid when core_done=1
- core_tag  in  128  recomputed tag, valid when core_done=1
- core_done  in  1  core completion, one-cycle or level
- busy  out  1  high in LOAD, RUN, CHECK
- auth_ok  out  1  high in SHOW
- auth_fail  out  1  high in FAIL
- seg  out  7  {g,f,e,d,c,b,a}, active-low
- an  out  8  digit enables, active-low

## Operation
- States: IDLE, LOAD, RUN, CHECK, SHOW, FAIL.
- IDLE: start=1 -> LOAD.
- SHOW or FAIL: start=1 -> LOAD (restart). start is ignored in LOAD, RUN and CHECK.
- LOAD actions:
  - core_c <= {CT_HI, sw}; tag_reg <= tag_ref; pt_reg <= 0.
  - core_start=1 for exactly this cycle; -> RUN.
- RUN: wait for core_done=1; on that cycle latch core_p into pt_cand and core_tag into tag_cand; -> CHECK.
- RUN timeout: wait counter reaches TIMEOUT-1 without core_done -> FAIL. The counter is cleared on entry to RUN.
- CHECK: full 128-bit equality tag_cand == tag_reg.
  - Equal: pt_reg <= pt_cand; -> SHOW.
  - Otherwise: pt_reg stays 0; -> FAIL.
  - Plaintext is never exposed on failure.
- core_done outside RUN is ignored.
- Display, in every state:
  - Digit i (0..7) shows nibble pt_reg[4i+3:4i].
  - an = ~(8'b1 << i).
  - In FAIL, all digits show F (7'b0001110).
  - In IDLE, LOAD, RUN and CHECK, an = 8'hFF (blank).
- Hex encoding (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- The scan counter is free-running and wraps at 2^SCAN_BITS.

## Timing
- All outputs are registered.
- Reset values:
  - state=IDLE; busy, auth_ok, auth_fail and core_start = 0
  - core_c=0, pt_reg=0, scan=0, an=8'hFF, seg=7'h7F
- Reset mid-operation aborts immediately. No core_start is issued after reset, and a late core_done is ignored.
- Latency:
  - start sampled in cycle N -> LOAD in N+1, with core_start=1 in N+1.
  - core_done in cycle M -> CHECK in M+1 -> SHOW or FAIL in M+2.
  - Status flags change in M+2.
- Display:
  - an/seg update one cycle after a change in scan digit select or in state.
  - Each digit dwells 2^(SCAN_BITS-3) cycles.
- If start and core_done are both high in RUN, core_done wins and start is ignored.

## Structure
- Package dec_pkg holds:
  - state enum
  - CT_HI = 112'h646e277420646563727970742074
  - FAIL_GLYPH and BLANK constants
- Sub-module hex_to_seg: 4-bit nibble -> 7-bit active-low pattern, purely combinational. The register stage is in the parent.
- The decryption core is external and not part of this block. The bench uses a behavioural model with configurable latency.

## Test plan
- Match: sw=16'h1234, model returns core_p low 32 bits 32'hCAFE1234 with core_tag==tag_ref after 20 cycles -> auth_ok=1 at M+2; digits 0..7 read 4,3,2,1,E,F,A,C.
- Mismatch: core_tag differs from tag_ref in bit 0 only -> auth_fail=1; pt_reg stays 0; all enabled digits show 7'b0001110.
- Timeout: model never asserts core_done -> FAIL exactly TIMEOUT cycles after RUN entry; core_start pulsed exactly once.
- Reset in RUN: rst asserted 5 cycles into RUN, then model raises core_done -> state IDLE; auth_ok=0, auth_fail=0, an=8'hFF.
- Restart: from SHOW, start with sw=16'h00FF -> pt_reg clears in LOAD, core_c[15:0]=16'h00FF, new result displayed; start held high during RUN produces no second core_start.
- Scan wrap, with SCAN_BITS=6 -> an cycles FE, FD, FB, F7, EF, DF, BF, 7F, FE with 8-cycle dwell.
